// File: rtl/seg7_pkg.sv
// Purpose : shared constants, types and segment table for the 8-digit
//           seven-segment scan driver.
// Ports   : none (package).
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned DATA_W     = NUM_DIGITS * NIB_W;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_NONE   = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns, entry n is hex digit n.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Pin-level drive of the display for one cycle.
  typedef struct packed {
    logic [NUM_DIGITS-1:0] an;
    logic [SEG_W-1:0]      cath;
  } seg7_drive_t;

  localparam seg7_drive_t DRIVE_DARK = '{an: AN_NONE, cath: SEG_BLANK};

  // Active-low one-hot anode enable for digit idx.
  function automatic logic [NUM_DIGITS-1:0] an_select(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Purpose : bundles the load side (data_in/valid_in/blank_mask) and the
//           display pins (AN/CATH/loaded) of the scan driver.
// Signals : data_in[31:0], valid_in, blank_mask[7:0]  -> driver
//           AN[7:0], CATH[6:0], loaded                <- driver
// Modports: master = producer/board side, slave = seg7_scan_driver.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic [DATA_W-1:0]     data_in;
  logic                  valid_in;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [NUM_DIGITS-1:0] AN;
  logic [SEG_W-1:0]      CATH;
  logic                  loaded;

  modport master (
    output data_in, valid_in, blank_mask,
    input  AN, CATH, loaded
  );

  modport slave (
    input  data_in, valid_in, blank_mask,
    output AN, CATH, loaded
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Purpose : combinational hex nibble to active-low seven-segment decode.
// Ports   : i_nibble[3:0] hex digit in
//           o_seg_c[6:0]  active-low {g,f,e,d,c,b,a} out (combinational)
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] i_nibble,
  output logic [SEG_W-1:0] o_seg_c
);

  assign o_seg_c = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Purpose : latches a 32-bit word on valid_in into a shadow register and
//           time-multiplexes it as 8 hex digits onto active-low AN/CATH
//           lines, with one dark cycle per digit slot against ghosting.
// Ports   : clk, rst_n (async active-low)
//           bus (seg7_scan_driver_if.slave): data_in, valid_in, blank_mask
//           in; AN, CATH, loaded out (all registered).
// Params  : REFRESH_DIV (>= 2) clock cycles per digit slot.
// Config  : define SEG7_LEADING_ZERO_BLANK_EN to darken leading zero
//           digits 7..1; digit 0 always shows once loaded.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_val;
  logic              r_loaded;
  seg7_drive_t       r_drive;

  logic              w_tick;
  logic [NIB_W-1:0]  w_nib;
  logic [SEG_W-1:0]  w_seg;
  logic              w_lz_dark;
  logic              w_lit;
  seg7_drive_t       w_drive_nxt;

  assign w_tick = (r_cnt == CNT_W'(REFRESH_DIV - 1));

  // Slot prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Shadow register; the last strobe wins, loaded sticks until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val    <= '0;
      r_loaded <= 1'b0;
    end else if (bus.valid_in) begin
      r_val    <= bus.data_in;
      r_loaded <= 1'b1;
    end
  end

  assign w_nib = NIB_W'(r_val >> {r_idx, 2'b00});

  seg7_hex_decode u_decode (
    .i_nibble (w_nib),
    .o_seg_c  (w_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Dark when this nibble and every nibble above it are zero.
  assign w_lz_dark = (r_idx != '0) && ((r_val >> {r_idx, 2'b00}) == '0);
`else
  assign w_lz_dark = 1'b0;
`endif

  assign w_lit = r_loaded && !bus.blank_mask[r_idx] && !w_lz_dark;

  // Next pin drive; the tick cycle loads dark so slot changes have a gap.
  always_comb begin
    w_drive_nxt = DRIVE_DARK;
    if (!w_tick && w_lit) begin
      w_drive_nxt.an   = an_select(r_idx);
      w_drive_nxt.cath = w_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drive <= DRIVE_DARK;
    end else begin
      r_drive <= w_drive_nxt;
    end
  end

  assign bus.AN     = r_drive.an;
  assign bus.CATH   = r_drive.cath;
  assign bus.loaded = r_loaded;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose : self-checking bench for seg7_scan_driver (REFRESH_DIV = 4).
//           Expected pins come from a cycle-count model: the slot position
//           and digit number are derived arithmetically from the number of
//           clock edges since reset release.
module tb_seg7_scan_driver;

  localparam int unsigned DIV = 4;
  localparam logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  logic rst_n;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned m_edges  = 0;
  logic [31:0] m_val    = '0;
  bit          m_loaded = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t edge=%0d", tag, got, want, $time, m_edges);
    end
  endtask

  // Pins visible in the cycle after edge number e+1, from the state before it.
  function automatic logic [14:0] model_out(input int unsigned e, input logic [31:0] v,
                                            input bit ld, input logic [7:0] mask);
    int unsigned pos;
    int unsigned dig;
    logic [3:0]  nib;
    logic [7:0]  an;
    bit          dark;
    pos  = e % DIV;
    dig  = (e / DIV) % 8;
    nib  = 4'(v >> (4 * dig));
    dark = (pos == DIV - 1) || !ld || mask[dig];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (dig != 0 && (v >> (4 * dig)) == 32'h0) dark = 1'b1;
`endif
    if (dark) return {8'hFF, 7'h7F};
    an = 8'hFF;
    an[dig] = 1'b0;
    return {an, SEG_REF[nib]};
  endfunction

  // One clock: drive inputs, predict, then compare on the falling edge.
  task automatic step(input bit v, input logic [31:0] d, input logic [7:0] mask);
    logic [14:0] want;
    bus.valid_in   = v;
    bus.data_in    = d;
    bus.blank_mask = mask;
    @(posedge clk);
    want = model_out(m_edges, m_val, m_loaded, mask);
    if (v) begin
      m_val    = d;
      m_loaded = 1'b1;
    end
    m_edges++;
    @(negedge clk);
    check_eq("AN", 32'(bus.AN), 32'(want[14:7]));
    check_eq("CATH", 32'(bus.CATH), 32'(want[6:0]));
    check_eq("loaded", 32'(bus.loaded), 32'(m_loaded));
  endtask

  task automatic run_idle(input int n, input logic [7:0] mask);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, mask);
  endtask

  task automatic model_reset();
    m_edges  = 0;
    m_val    = '0;
    m_loaded = 1'b0;
  endtask

  initial begin
    bus.valid_in   = 1'b0;
    bus.data_in    = '0;
    bus.blank_mask = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_AN", 32'(bus.AN), 32'h0000_00FF);
    check_eq("rst_CATH", 32'(bus.CATH), 32'h0000_007F);
    check_eq("rst_loaded", 32'(bus.loaded), 32'h0);
    rst_n = 1'b1;
    model_reset();

    // Three frames with nothing loaded: everything dark.
    run_idle(3 * 8 * DIV, 8'h00);

    // Full frame of a mixed hex word.
    step(1'b1, 32'h89AB_CDEF, 8'h00);
    run_idle(8 * DIV + 4, 8'h00);

    // Load landing exactly on the tick cycle.
    step(1'b1, 32'h0, 8'h00);
    run_idle(3, 8'h00);
    while (m_edges % DIV != DIV - 1) step(1'b0, 32'h0, 8'h00);
    step(1'b1, 32'h1111_1111, 8'h00);
    run_idle(DIV + 2, 8'h00);
    check_eq("tick_load_loaded", 32'(bus.loaded), 32'h1);

    // Upper four digits masked.
    step(1'b1, 32'h1234_5678, 8'hF0);
    run_idle(8 * DIV + 4, 8'hF0);

    // Leading-zero candidates (lit normally in the default build).
    step(1'b1, 32'h0000_001A, 8'h00);
    run_idle(8 * DIV + 4, 8'h00);
    step(1'b1, 32'h0, 8'h00);
    run_idle(8 * DIV + 4, 8'h00);

    // Back-to-back strobes: only the last survives.
    step(1'b1, 32'hDEAD_BEEF, 8'h00);
    step(1'b1, 32'h7654_3210, 8'h00);
    run_idle(8 * DIV, 8'h00);

    // Randomized loads, masks and values with varied leading zeros.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      logic [7:0]  mask;
      bit          v;
      d    = $urandom >> (4 * $urandom_range(0, 7));
      mask = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      v    = ($urandom_range(0, 7) == 0);
      step(v, d, mask);
    end

    // Asynchronous reset in the middle of digit 5.
    step(1'b1, 32'hFFFF_FFFF, 8'h00);
    while (((m_edges / DIV) % 8) != 5 || (m_edges % DIV) != 2) step(1'b0, 32'h0, 8'h00);
    check_eq("pre_rst_AN", 32'(bus.AN), 32'h0000_00DF);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_AN", 32'(bus.AN), 32'h0000_00FF);
    check_eq("async_CATH", 32'(bus.CATH), 32'h0000_007F);
    check_eq("async_loaded", 32'(bus.loaded), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_idle(2 * DIV + 3, 8'h00);
    step(1'b1, 32'h0000_00C5, 8'h00);
    run_idle(8 * DIV + 4, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
